axis_to_ram_writer: RTL and testbench



---
 rtl/axis_to_ram_writer.sv | 157 +++++++++++++++
 tb/tb_axis_to_ram_writer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axis_to_ram_writer.sv
// Writes one AXI-stream packet into a word-addressed RAM from address 0 and
// reports its byte length and error on a descriptor handshake. The optional
// feature AXIS_RAM_WR_ZERO_PAD_EN zeroes the bytes at and above mod on the eop beat.
module axis_to_ram_writer #(
  parameter int unsigned DAT_BYTS  = 8,
  parameter int unsigned RAM_DEPTH = 64,
  parameter int unsigned LEN_BITS  = $clog2(RAM_DEPTH * DAT_BYTS + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [DAT_BYTS*8-1:0]        i_axi_dat,
  input  logic                         i_axi_val,
  input  logic                         i_axi_sop,
  input  logic                         i_axi_eop,
  input  logic                         i_axi_err,
  input  logic [$clog2(DAT_BYTS)-1:0]  i_axi_mod,
  output logic                         i_axi_rdy,
  output logic                         o_ram_en,
  output logic                         o_ram_we,
  output logic                         o_ram_re,
  output logic [$clog2(RAM_DEPTH)-1:0] o_ram_a,
  output logic [DAT_BYTS*8-1:0]        o_ram_d,
  output logic                         o_pkt_val,
  input  logic                         i_pkt_rdy,
  output logic [LEN_BITS-1:0]          o_pkt_len,
  output logic                         o_pkt_err
);

  localparam int unsigned ABITS = $clog2(RAM_DEPTH);
  localparam int unsigned CBITS = $clog2(RAM_DEPTH + 1);
  localparam logic [LEN_BITS-1:0] SatLen = LEN_BITS'(RAM_DEPTH * DAT_BYTS);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [CBITS-1:0]      beats_q, beats_d;
  logic                  err_q, err_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic                  val_q, val_d;
  logic                  rdy_q, rdy_d;
  logic                  ram_en_q;
  logic [ABITS-1:0]      ram_a_q;
  logic [DAT_BYTS*8-1:0] ram_d_q;

  logic                  accept, full, wr_en;
  logic [ABITS-1:0]      wr_a;
  logic [DAT_BYTS*8-1:0] wr_dat;
  logic [LEN_BITS-1:0]   last_bytes;

  assign accept     = i_axi_val && rdy_q;
  assign full       = (beats_q == CBITS'(RAM_DEPTH));
  assign last_bytes = (i_axi_mod == '0) ? LEN_BITS'(DAT_BYTS) : LEN_BITS'(i_axi_mod);

  always_comb begin
    wr_dat = i_axi_dat;
`ifdef AXIS_RAM_WR_ZERO_PAD_EN
    for (int b = 0; b < int'(DAT_BYTS); b++) begin
      if (i_axi_eop && (i_axi_mod != '0) && (b >= int'(i_axi_mod))) begin
        wr_dat[b*8 +: 8] = 8'h00;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    err_d   = err_q;
    len_d   = len_q;
    val_d   = val_q;
    wr_en   = 1'b0;
    wr_a    = beats_q[ABITS-1:0];
    unique case (state_q)
      StIdle: begin
        // Beats without sop are discarded until a packet starts.
        if (accept && i_axi_sop) begin
          wr_en   = 1'b1;
          wr_a    = '0;
          beats_d = CBITS'(1);
          err_d   = i_axi_err;
          if (i_axi_eop) begin
            len_d   = last_bytes;
            state_d = StDone;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (accept) begin
          err_d = err_q | i_axi_err | i_axi_sop;
          if (full) begin
            err_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            beats_d = beats_q + CBITS'(1);
          end
          if (i_axi_eop) begin
            len_d   = full ? SatLen
                           : LEN_BITS'(beats_q) * LEN_BITS'(DAT_BYTS) + last_bytes;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // First DONE cycle lets the final write commit before raising valid.
        if (!val_q) begin
          val_d = 1'b1;
        end else if (i_pkt_rdy) begin
          val_d   = 1'b0;
          beats_d = '0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    rdy_d = (state_d != StDone);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      beats_q  <= '0;
      err_q    <= 1'b0;
      len_q    <= '0;
      val_q    <= 1'b0;
      rdy_q    <= 1'b0;
      ram_en_q <= 1'b0;
      ram_a_q  <= '0;
      ram_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      beats_q  <= beats_d;
      err_q    <= err_d;
      len_q    <= len_d;
      val_q    <= val_d;
      rdy_q    <= rdy_d;
      ram_en_q <= wr_en;
      if (wr_en) begin
        ram_a_q <= wr_a;
        ram_d_q <= wr_dat;
      end
    end
  end

  assign i_axi_rdy = rdy_q;
  assign o_ram_en  = ram_en_q;
  assign o_ram_we  = ram_en_q;
  assign o_ram_re  = 1'b0;
  assign o_ram_a   = ram_a_q;
  assign o_ram_d   = ram_d_q;
  assign o_pkt_val = val_q;
  assign o_pkt_len = len_q;
  assign o_pkt_err = err_q;

endmodule

// File: tb/tb_axis_to_ram_writer.sv
// Scoreboard bench for axis_to_ram_writer (RAM_DEPTH=4 so overflow is reachable).
module tb_axis_to_ram_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] dat;
  logic        val, sop, eop, err;
  logic [2:0]  mod;
  logic        axi_rdy;
  logic        ram_en, ram_we, ram_re;
  logic [1:0]  ram_a;
  logic [63:0] ram_d;
  logic        pkt_val, pkt_rdy;
  logic [5:0]  pkt_len;
  logic        pkt_err;

  int tests = 0;
  int fails = 0;

  typedef struct {logic [1:0] a; logic [63:0] d;} wr_t;
  typedef struct {logic [5:0] len; logic err;} desc_t;
  wr_t   wq[$];
  desc_t dq[$];

  always #5 clk = ~clk;

  axis_to_ram_writer #(.DAT_BYTS(8), .RAM_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_axi_dat(dat), .i_axi_val(val), .i_axi_sop(sop),
    .i_axi_eop(eop), .i_axi_err(err), .i_axi_mod(mod), .i_axi_rdy(axi_rdy),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_re(ram_re), .o_ram_a(ram_a),
    .o_ram_d(ram_d), .o_pkt_val(pkt_val), .i_pkt_rdy(pkt_rdy), .o_pkt_len(pkt_len),
    .o_pkt_err(pkt_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_d(input logic [63:0] dt, input logic e,
                                        input logic [2:0] m);
    logic [63:0] padded;
    padded = dt;
    for (int b = 0; b < 8; b++) if (e && m != 0 && b >= int'(m)) padded[b*8 +: 8] = 8'h00;
`ifdef AXIS_RAM_WR_ZERO_PAD_EN
    return padded;
`else
    return dt;
`endif
  endfunction

  // Monitor: pops expected writes/descriptors whenever the DUT presents one.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_en) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", {62'd0, ram_a}, 64'hFFFF);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", {62'd0, ram_a}, {62'd0, w.a});
          chk("wr_data", ram_d, w.d);
          chk("wr_we_re", {62'd0, ram_we, ram_re}, 64'd2);
        end
      end
      if (pkt_val && pkt_rdy) begin
        if (dq.size() == 0) begin
          chk("unexpected_desc", {58'd0, pkt_len}, 64'hFFFF);
        end else begin
          desc_t x;
          x = dq.pop_front();
          chk("desc_len", {58'd0, pkt_len}, {58'd0, x.len});
          chk("desc_err", {63'd0, pkt_err}, {63'd0, x.err});
        end
      end
    end
  end

  task automatic send(input logic [63:0] dt, input logic s, input logic e, input logic [2:0] m,
                      input logic er, input logic wr, input logic [1:0] wa);
    int n;
    n = 0;
    dat = dt; sop = s; eop = e; mod = m; err = er; val = 1'b1;
    @(negedge clk);
    while (!axi_rdy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: beat %h not accepted", dt);
    end
    if (wr) wq.push_back('{a: wa, d: exp_d(dt, e, m)});
    @(posedge clk);
    #1;
    val = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0;
  endtask

  task automatic wait_desc();
    int n;
    n = 0;
    while (dq.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("desc_drained", 64'(dq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'h0101010101010101 * 64'(i + 1);
  endfunction

  initial begin
    rst = 1'b1; dat = '0; val = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0; mod = '0;
    pkt_rdy = 1'b1;
    @(negedge clk);
    chk("rst_axi_rdy", {63'd0, axi_rdy}, 64'd0);
    chk("rst_outs", {60'd0, ram_en, ram_we, pkt_val, pkt_err}, 64'd0);
    chk("rst_len", {58'd0, pkt_len}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Single beat sop+eop, mod=3.
    dq.push_back('{len: 6'd3, err: 1'b0});
    send(64'h1122334455667788, 1, 1, 3'd3, 0, 1, 2'd0);
    @(negedge clk);
    chk("t1_val_n1", {63'd0, pkt_val}, 64'd0);
    chk("t1_en_n1", {63'd0, ram_en}, 64'd1);
    @(negedge clk);
    chk("t1_val_n2", {63'd0, pkt_val}, 64'd1);
    wait_desc();

    // 20-byte packet with the descriptor held off for 5 cycles.
    pkt_rdy = 1'b0;
    dq.push_back('{len: 6'd20, err: 1'b0});
    for (int i = 0; i < 3; i++) send(pat(i), i == 0, i == 2, (i == 2) ? 3'd4 : 3'd0, 0, 1, 2'(i));
    repeat (5) begin
      @(negedge clk);
      chk("t2_rdy_done", {63'd0, axi_rdy}, 64'd0);
    end
    chk("t2_val_held", {63'd0, pkt_val}, 64'd1);
    @(posedge clk); #1; pkt_rdy = 1'b1;
    @(negedge clk);
    chk("t2_rdy_hs", {63'd0, axi_rdy}, 64'd0);
    @(negedge clk);
    chk("t2_rdy_after", {62'd0, axi_rdy, pkt_val}, 64'd2);
    wait_desc();

    // Overflow: 6 beats into 4 words.
    dq.push_back('{len: 6'd32, err: 1'b1});
    for (int i = 0; i < 6; i++) send(pat(i + 8), i == 0, i == 5, 3'd0, 0, i < 4, 2'(i));
    wait_desc();

    // Stray non-sop beat, then a 2-beat packet.
    send(64'hDEADBEEFDEADBEEF, 0, 0, 3'd0, 0, 0, 2'd0);
    dq.push_back('{len: 6'd16, err: 1'b0});
    send(pat(20), 1, 0, 3'd0, 0, 1, 2'd0);
    send(pat(21), 0, 1, 3'd0, 0, 1, 2'd1);
    wait_desc();

    // Stream error on beat 2, then a repeated sop on beat 2.
    dq.push_back('{len: 6'd24, err: 1'b1});
    for (int i = 0; i < 3; i++) send(pat(i + 30), i == 0, i == 2, 3'd0, i == 1, 1, 2'(i));
    wait_desc();
    dq.push_back('{len: 6'd24, err: 1'b1});
    for (int i = 0; i < 3; i++) send(pat(i + 40), i < 2, i == 2, 3'd0, 0, 1, 2'(i));
    wait_desc();

    // Reset after 2 of 4 beats; the second beat's write is killed by reset.
    send(pat(50), 1, 0, 3'd0, 0, 1, 2'd0);
    send(pat(51), 0, 0, 3'd0, 0, 0, 2'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", {61'd0, ram_en, pkt_val, axi_rdy}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    send(pat(52), 0, 0, 3'd0, 0, 0, 2'd2);
    send(pat(53), 0, 1, 3'd0, 0, 0, 2'd3);
    dq.push_back('{len: 6'd5, err: 1'b0});
    send(64'hA1B2C3D4E5F60718, 1, 1, 3'd5, 0, 1, 2'd0);
    wait_desc();

    repeat (4) @(negedge clk);
    chk("writes_drained", 64'(wq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
